uart_rx_monitor: RTL and testbench

//  Serial receiver on the CPU's UART transmit line: deserialises 8N1 frames

---
 rtl/uart_rx_monitor.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 serial receiver with a first-word-fall-through byte FIFO.
// Samples each bit at its centre. Stop-bit errors and dropped bytes are
// reported as one-cycle pulses.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  output logic [7:0]                  out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        frame_err,
  output logic                        overflow
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          rx_m, rx_s;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    sr, sr_nx;
  logic          push_req, ferr_nx;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp, rp_nx;
  logic          full, pop, push, ovf;
  logic [AW:0]   after_pop, occ_nx;

  // Two-flop synchroniser; presets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Receive FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sr    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      sr    <= sr_nx;
    end
  end

  // Next-state logic: half a bit to the start-bit centre, then full bits.
  // Leaving STOP at mid-stop-bit lets a back-to-back start edge be caught.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    sr_nx    = sr;
    push_req = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_nx = '0;
          if (rx_s) begin
            state_nx = IDLE;
          end else begin
            state_nx = DATA;
            idx_nx   = '0;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          sr_nx  = {rx_s, sr[7:1]};
          cnt_nx = '0;
          if (idx == 3'd7) state_nx = STOP;
          else             idx_nx   = idx + 3'd1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          if (rx_s) push_req = 1'b1;
          else      ferr_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign out_valid = (fifo_count != '0);

  // Fullness is judged on the pre-pop count, so a full FIFO drops the byte
  // even when the consumer pops in the same cycle.
  always_comb begin
    full      = (fifo_count == DEPTH);
    pop       = out_valid & out_ready;
    push      = push_req & ~full;
    ovf       = push_req & full;
    rp_nx     = pop ? rp + AW'(1) : rp;
    after_pop = fifo_count - (AW+1)'(pop);
    occ_nx    = after_pop + (AW+1)'(push);
  end

  // Byte storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= sr;
  end

  // FIFO pointers, occupancy, registered head and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp         <= '0;
      rp         <= '0;
      fifo_count <= '0;
      out_data   <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      rp         <= rp_nx;
      fifo_count <= occ_nx;
      frame_err  <= ferr_nx;
      overflow   <= ovf;
      // New head is the incoming byte when nothing else remains; otherwise
      // it is already in storage at the post-pop read pointer.
      if (push && after_pop == '0) out_data <= sr;
      else if (after_pop != '0)    out_data <= mem[rp_nx];
    end
  end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: directed frames against a queue model of the receiver.
module tb_uart_rx_monitor;
  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  // Edge at which a frame's stop bit is judged, counted from the edge after
  // which the start bit is driven: 2 synchroniser flops + 1 IDLE decision,
  // half a bit to the start centre, then 8 data bits and the stop bit.
  localparam int LAT = 3 + CPB/2 + 9*CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [3:0] fifo_count;
  logic       busy, frame_err, overflow;

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .busy(busy),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic [7:0]  d;
    bit          ok;
  } ev_t;

  ev_t        sched[$];
  logic [7:0] mq[$];
  logic [7:0] popped[$];
  bit         exp_ferr = 0, exp_ovf = 0;
  int         ferr_seen = 0, ovf_seen = 0;
  int         nchk = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare DUT against the model, then advance the model to the next edge.
  bit         was_full, do_pop, have_push;
  logic [7:0] push_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      sched.delete();
      exp_ferr = 0;
      exp_ovf  = 0;
      chk("rst_valid", out_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovf", overflow, 0);
    end else begin
      chk("valid", out_valid, mq.size() != 0);
      chk("count", fifo_count, mq.size());
      if (mq.size() != 0) chk("data", out_data, mq[0]);
      chk("frame_err", frame_err, exp_ferr);
      chk("overflow", overflow, exp_ovf);
      if (frame_err) ferr_seen++;
      if (overflow)  ovf_seen++;
      was_full  = (mq.size() == DEPTH);
      do_pop    = (mq.size() != 0) && out_ready;
      have_push = 0;
      push_d    = '0;
      exp_ferr  = 0;
      exp_ovf   = 0;
      for (int i = sched.size() - 1; i >= 0; i--) begin
        if (sched[i].at == cyc + 1) begin
          if (!sched[i].ok)  exp_ferr = 1;
          else if (was_full) exp_ovf  = 1;
          else begin
            have_push = 1;
            push_d    = sched[i].d;
          end
          sched.delete(i);
        end
      end
      if (do_pop)    popped.push_back(mq.pop_front());
      if (have_push) mq.push_back(push_d);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle(CPB);
  endtask

  task automatic send(input logic [7:0] d, input bit stop);
    sched.push_back('{cyc + LAT, d, stop});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((mq.size() != 0 || out_valid) && n < 200) begin
      idle(1);
      n++;
    end
    chk("drain_done", n < 200, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, then long idle line
    idle(3);
    rst_n = 1'b1;
    idle(100);
    chk("t1_busy", busy, 0);
    chk("t1_valid", out_valid, 0);
    chk("t1_count", fifo_count, 0);
    chk("t1_pulses", ferr_seen + ovf_seen, 0);

    // 2: two back-to-back frames held, then drained in order
    send(8'h55, 1'b1);
    send(8'hA3, 1'b1);
    idle(20);
    chk("t2_count", fifo_count, 2);
    chk("t2_head", out_data, 8'h55);
    popped.delete();
    drain();
    chk("t2_npop", popped.size(), 2);
    if (popped.size() == 2) begin
      chk("t2_pop0", popped[0], 8'h55);
      chk("t2_pop1", popped[1], 8'hA3);
    end
    chk("t2_valid", out_valid, 0);

    // 3: 5-cycle low glitch is rejected at the start-bit centre
    rx = 1'b0;
    idle(4);
    chk("t3_busy_hi", busy, 1);
    idle(1);
    rx = 1'b1;
    idle(30);
    chk("t3_busy_lo", busy, 0);
    chk("t3_count", fifo_count, 0);
    chk("t3_ferr", ferr_seen, 0);

    // 4: stop bit low -> one frame_err, nothing stored
    send(8'h3C, 1'b0);
    rx = 1'b1;
    idle(40);
    chk("t4_ferr", ferr_seen, 1);
    chk("t4_count", fifo_count, 0);
    chk("t4_busy", busy, 0);

    // 5: nine bytes into an 8-deep FIFO
    for (int i = 0; i < 9; i++) send(8'(i), 1'b1);
    idle(10);
    chk("t5_count", fifo_count, 8);
    chk("t5_ovf", ovf_seen, 1);
    popped.delete();
    drain();
    chk("t5_npop", popped.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < popped.size()) chk("t5_pop", popped[i], 32'(i));

    // 6: reset mid-frame flushes FIFO and aborts the partial byte
    send(8'h11, 1'b1);
    idle(5);
    chk("t6_pre_count", fifo_count, 1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    idle(4);
    chk("t6_busy", busy, 1);
    rst_n = 1'b0;
    rx    = 1'b1;
    idle(3);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_valid", out_valid, 0);
    rst_n = 1'b1;
    idle(5);
    send(8'h7E, 1'b1);
    idle(10);
    chk("t6_count", fifo_count, 1);
    popped.delete();
    drain();
    chk("t6_npop", popped.size(), 1);
    if (popped.size() == 1) chk("t6_pop", popped[0], 8'h7E);
    chk("t6_ferr", ferr_seen, 1);
    chk("t6_ovf", ovf_seen, 1);

    idle(5);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
